// File: rtl/ysyx_24110006_axi_rd_arbiter.sv
// Two-master (IFU/LSU) AXI4 read-channel arbiter: one burst in flight, R beats steered by state.
// Define ARB_RR_EN for round-robin arbitration; otherwise the LSU has fixed priority.
module ysyx_24110006_axi_rd_arbiter (
    input  logic        clock,
    input  logic        reset,
    input  logic        i_ifu_arvalid,
    output logic        o_ifu_arready,
    input  logic [31:0] i_ifu_araddr,
    input  logic [7:0]  i_ifu_arlen,
    output logic        o_ifu_rvalid,
    input  logic        i_ifu_rready,
    output logic [31:0] o_ifu_rdata,
    output logic [1:0]  o_ifu_rresp,
    output logic        o_ifu_rlast,
    input  logic        i_lsu_arvalid,
    output logic        o_lsu_arready,
    input  logic [31:0] i_lsu_araddr,
    input  logic [7:0]  i_lsu_arlen,
    input  logic [2:0]  i_lsu_arsize,
    output logic        o_lsu_rvalid,
    input  logic        i_lsu_rready,
    output logic [31:0] o_lsu_rdata,
    output logic [1:0]  o_lsu_rresp,
    output logic        o_lsu_rlast,
    output logic        o_axi_arvalid,
    input  logic        i_axi_arready,
    output logic [31:0] o_axi_araddr,
    output logic [3:0]  o_axi_arid,
    output logic [7:0]  o_axi_arlen,
    output logic [2:0]  o_axi_arsize,
    output logic [1:0]  o_axi_arburst,
    input  logic        i_axi_rvalid,
    output logic        o_axi_rready,
    input  logic [31:0] i_axi_rdata,
    input  logic [1:0]  i_axi_rresp,
    input  logic        i_axi_rlast,
    input  logic [3:0]  i_axi_rid
);

    typedef enum logic [2:0] {IDLE, AR_IFU, AR_LSU, R_IFU, R_LSU} state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [7:0]  len_q, len_d;
    logic [2:0]  size_q, size_d;
    logic        idLsu_q, idLsu_d;
    logic [7:0]  beat_q, beat_d;
    logic        preferIfu;
    logic        ifuWin;
    logic        lastBeat;
    logic        unusedRid;

    // Routing is purely by state, so the returned ID carries no information here.
    assign unusedRid = ^i_axi_rid;

`ifdef ARB_RR_EN
    logic lastLsu_q, lastLsu_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            lastLsu_q <= 1'b1;
        end else begin
            lastLsu_q <= lastLsu_d;
        end
    end

    assign preferIfu = lastLsu_q;
`else
    assign preferIfu = 1'b0;
`endif

    assign ifuWin   = i_ifu_arvalid && (!i_lsu_arvalid || preferIfu);
    assign lastBeat = i_axi_rlast || (beat_q == len_q);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            size_q  <= '0;
            idLsu_q <= 1'b0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            size_q  <= size_d;
            idLsu_q <= idLsu_d;
            beat_q  <= beat_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        len_d         = len_q;
        size_d        = size_q;
        idLsu_d       = idLsu_q;
        beat_d        = beat_q;
`ifdef ARB_RR_EN
        lastLsu_d     = lastLsu_q;
`endif
        o_ifu_arready = 1'b0;
        o_lsu_arready = 1'b0;
        o_ifu_rvalid  = 1'b0;
        o_lsu_rvalid  = 1'b0;
        o_ifu_rlast   = 1'b0;
        o_lsu_rlast   = 1'b0;
        o_axi_arvalid = 1'b0;
        o_axi_rready  = 1'b0;
        case (state_q)
            IDLE: begin
                o_ifu_arready = ifuWin;
                o_lsu_arready = !ifuWin;
                if (ifuWin) begin
                    addr_d  = i_ifu_araddr;
                    len_d   = i_ifu_arlen;
                    size_d  = 3'b010;
                    idLsu_d = 1'b0;
                    beat_d  = '0;
                    state_d = AR_IFU;
`ifdef ARB_RR_EN
                    lastLsu_d = 1'b0;
`endif
                end else if (i_lsu_arvalid) begin
                    addr_d  = i_lsu_araddr;
                    len_d   = i_lsu_arlen;
                    size_d  = i_lsu_arsize;
                    idLsu_d = 1'b1;
                    beat_d  = '0;
                    state_d = AR_LSU;
`ifdef ARB_RR_EN
                    lastLsu_d = 1'b1;
`endif
                end
            end
            AR_IFU, AR_LSU: begin
                o_axi_arvalid = 1'b1;
                if (i_axi_arready) begin
                    state_d = (state_q == AR_IFU) ? R_IFU : R_LSU;
                end
            end
            R_IFU: begin
                o_axi_rready = i_ifu_rready;
                o_ifu_rvalid = i_axi_rvalid;
                o_ifu_rlast  = lastBeat;
                if (i_axi_rvalid && i_ifu_rready) begin
                    if (lastBeat) state_d = IDLE;
                    else          beat_d  = beat_q + 8'd1;
                end
            end
            R_LSU: begin
                o_axi_rready = i_lsu_rready;
                o_lsu_rvalid = i_axi_rvalid;
                o_lsu_rlast  = lastBeat;
                if (i_axi_rvalid && i_lsu_rready) begin
                    if (lastBeat) state_d = IDLE;
                    else          beat_d  = beat_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign o_axi_araddr  = addr_q;
    assign o_axi_arlen   = len_q;
    assign o_axi_arsize  = size_q;
    assign o_axi_arid    = {3'b000, idLsu_q};
    assign o_axi_arburst = (state_q == AR_IFU || state_q == AR_LSU) ? 2'b01 : 2'b00;

    assign o_ifu_rdata = i_axi_rdata;
    assign o_ifu_rresp = i_axi_rresp;
    assign o_lsu_rdata = i_axi_rdata;
    assign o_lsu_rresp = i_axi_rresp;

endmodule

// File: doc/ysyx_24110006_axi_rd_arbiter.md
# ysyx_24110006_axi_rd_arbiter

Two-master AXI4 read-channel arbiter placed between the core's instruction fetch unit (IFU) and load/store unit (LSU) and the single read port of the crossbar. It accepts one AR request at a time, owns the downstream read channel until the final R beat of that burst, and steers R beats back to the winning master. The LSU write channel does not pass through this block; it connects to the crossbar directly.

## Interface
- No parameters. Address width 32, data width 32, ID width 4, all fixed.
- clock  in  1  single clock, all logic rising-edge.
- reset  in  1  synchronous, active-high.
- i_ifu_arvalid / o_ifu_arready  in/out  1/1  IFU AR handshake.
- i_ifu_araddr, i_ifu_arlen  in  32, 8  IFU request; size fixed 3'b010, burst fixed INCR.
- o_ifu_rvalid / i_ifu_rready  out/in  1/1  IFU R handshake.
- o_ifu_rdata, o_ifu_rresp, o_ifu_rlast  out  32, 2, 1  IFU R payload.
- i_lsu_arvalid / o_lsu_arready  in/out  1/1  LSU AR handshake.
- i_lsu_araddr, i_lsu_arlen, i_lsu_arsize  in  32, 8, 3  LSU request; burst fixed INCR.
- o_lsu_rvalid / i_lsu_rready  out/in  1/1  LSU R handshake.
- o_lsu_rdata, o_lsu_rresp, o_lsu_rlast  out  32, 2, 1  LSU R payload.
- o_axi_arvalid / i_axi_arready  out/in  1/1  downstream AR handshake.
- o_axi_araddr, o_axi_arid, o_axi_arlen, o_axi_arsize, o_axi_arburst  out  32, 4, 8, 3, 2  downstream AR payload.
- i_axi_rvalid / o_axi_rready  in/out  1/1  downstream R handshake.
- i_axi_rdata, i_axi_rresp, i_axi_rlast, i_axi_rid  in  32, 2, 1, 4  downstream R payload.

## Operation
- States: IDLE, AR_IFU, AR_LSU, R_IFU, R_LSU.
- IDLE: o_x_arready=1 combinationally for the arbitration winner only, 0 for the loser. On winner's arvalid, latch addr/len/size into request register, clear beat counter, go to AR_x.
- AR_x: o_axi_arvalid=1, payload from request register; arid=4'd0 for IFU, 4'd1 for LSU; arburst=2'b01. Both o_x_arready=0. On i_axi_arready go to R_x.
- R_x: o_axi_rready=i_x_rready; o_x_rvalid=i_axi_rvalid; rdata/rresp forwarded; other master's rvalid=0. Each handshake increments 8-bit beat counter.
- Last beat = i_axi_rlast OR (beat counter == latched arlen). o_x_rlast driven from this OR. On last-beat handshake go to IDLE.
- i_axi_rid is ignored for routing; routing is by state only.
- rresp SLVERR/DECERR forwarded unchanged; no retry, burst still completes.
- Loser's request held by its master (arvalid stays high) and served after return to IDLE.

## Timing
- Reset values: all o_*valid=0, o_*ready=0 except o_x_arready per IDLE rule, o_x_rlast=0, o_axi_ar* payload=0, state=IDLE, beat counter=0, last-grant=LSU.
- Request accepted at cycle N (IDLE); o_axi_arvalid=1 at N+1 earliest.
- R path fully combinational in R_x: zero added latency per beat.
- After last beat at cycle M, state IDLE at M+1; new arready possible at M+1. Minimum one idle cycle between bursts.
- Reset mid-burst: state to IDLE next edge; downstream outstanding beats dropped (o_axi_rready=0); whole SoC resets together so no drain.
- o_axi_arvalid never deasserts before i_axi_arready while not in reset.
- arlen=0: single beat, last asserted on first handshake.
- arlen=255: counter reaches 255 without overflow; wrap never observed.

## Configuration
- ARB_RR_EN defined: round-robin; on simultaneous requests in IDLE the master not granted last wins; last-grant register updated on each grant.
- ARB_RR_EN undefined: fixed priority, LSU always wins simultaneous requests; last-grant register not implemented.

## Test plan
- IFU only, araddr=0x8000_0000, arlen=3, slave returns 4 beats 0x11..0x44 with rlast on 4th -> IFU sees 4 beats, o_ifu_rlast on 4th, o_axi_arid=0, LSU rvalid stays 0.
- Simultaneous IFU/LSU requests, fixed priority -> LSU served first (arid=1), IFU AR issued one cycle after LSU last beat; with ARB_RR_EN and last-grant=LSU -> IFU first.
- LSU arlen=1, slave never asserts rlast -> burst ends after 2nd handshake, o_lsu_rlast=1 on beat 2, state IDLE next cycle.
- Downstream arready held low 5 cycles -> o_axi_arvalid and payload stable 5 cycles, both o_x_arready=0 throughout.
- i_ifu_rready low on beat 2 of 4 for 3 cycles -> o_axi_rready low same cycles, no beat lost or duplicated, rresp=2'b10 on beat 3 forwarded unchanged.
- Reset asserted during beat 2 of IFU arlen=7 burst -> next cycle all valids 0, state IDLE, new LSU request granted after reset release.
